ats_flow_state_ctrl: RTL



---
 rtl/ats_pkg.sv | 27 ++
 rtl/ats_flow_table.sv | 57 +++++
 rtl/ats_flow_state_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ats_pkg.sv
// Shared constants, FSM state encoding and flow-configuration record for the
// ATS per-flow state controller.
package ats_pkg;
  localparam int unsigned TIME_WIDTH     = 59;
  localparam int unsigned GROUP_NUM      = 4;
  localparam int unsigned GROUP_ID_WIDTH = $clog2(GROUP_NUM);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOOKUP    = 4'd1,
    ST_START     = 4'd2,
    ST_MATCH     = 4'd3,
    ST_FINISH    = 4'd4,
    ST_WAIT_OK   = 4'd5,
    ST_WRITEBACK = 4'd6,
    ST_RESULT    = 4'd7,
    ST_RELEASE   = 4'd8
  } ats_state_e;

  typedef struct packed {
    logic                      valid;
    logic [GROUP_ID_WIDTH-1:0] group;
    logic [31:0]               cir;
    logic [31:0]               cbs;
    logic [TIME_WIDTH-1:0]     max_res;
  } flow_cfg_t;
endpackage

// File: rtl/ats_flow_table.sv
// Per-flow configuration / bucket-empty-time and per-group eligibility-time
// register file with a registered read port; config writes beat state writeback.
module ats_flow_table
  import ats_pkg::*;
#(
  parameter int unsigned FLOW_NUM      = 8,
  parameter int unsigned FLOW_ID_WIDTH = $clog2(FLOW_NUM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_wr_en,
  input  logic [FLOW_ID_WIDTH-1:0]  cfg_flow_id,
  input  flow_cfg_t                 cfg_data,
  input  logic                      st_wr_en,
  input  logic [FLOW_ID_WIDTH-1:0]  st_flow_id,
  input  logic [GROUP_ID_WIDTH-1:0] st_group_id,
  input  logic [TIME_WIDTH-1:0]     st_bucket_empty_time,
  input  logic [TIME_WIDTH-1:0]     st_group_eligibility_time,
  input  logic [FLOW_ID_WIDTH-1:0]  rd_flow_id,
  output flow_cfg_t                 rd_cfg,
  output logic [TIME_WIDTH-1:0]     rd_bucket_empty_time,
  output logic [TIME_WIDTH-1:0]     rd_group_eligibility_time
);

  flow_cfg_t             cfg_mem   [FLOW_NUM];
  logic [TIME_WIDTH-1:0] bet_mem   [FLOW_NUM];
  logic [TIME_WIDTH-1:0] group_mem [GROUP_NUM];

  // Config write is issued after writeback so it wins on the same flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FLOW_NUM); i++) begin
        cfg_mem[i] <= '0;
        bet_mem[i] <= '0;
      end
      for (int g = 0; g < int'(GROUP_NUM); g++) begin
        group_mem[g] <= '0;
      end
      rd_cfg                    <= '0;
      rd_bucket_empty_time      <= '0;
      rd_group_eligibility_time <= '0;
    end else begin
      if (st_wr_en) begin
        bet_mem[st_flow_id]    <= st_bucket_empty_time;
        group_mem[st_group_id] <= st_group_eligibility_time;
      end
      if (cfg_wr_en) begin
        cfg_mem[cfg_flow_id] <= cfg_data;
        bet_mem[cfg_flow_id] <= '0;
      end
      rd_cfg                    <= cfg_mem[rd_flow_id];
      rd_bucket_empty_time      <= bet_mem[rd_flow_id];
      rd_group_eligibility_time <= group_mem[cfg_mem[rd_flow_id].group];
    end
  end

endmodule

// File: rtl/ats_flow_state_ctrl.sv
// Per-flow ATS state controller: looks up flow config/state, runs the token
// bucket start/match/read-end handshake, writes state back and emits the result.
module ats_flow_state_ctrl
  import ats_pkg::*;
#(
  parameter int unsigned FLOW_NUM      = 8,
  parameter int unsigned TB_TIMEOUT    = 64,
  parameter int unsigned FLOW_ID_WIDTH = $clog2(FLOW_NUM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [FLOW_ID_WIDTH-1:0]  desc_flow_id,
  input  logic [15:0]               desc_frame_length,
  input  logic [TIME_WIDTH-1:0]     desc_arrival_time,
  input  logic                      cfg_wr_en,
  input  logic [FLOW_ID_WIDTH-1:0]  cfg_flow_id,
  input  logic [GROUP_ID_WIDTH-1:0] cfg_group_id,
  input  logic [31:0]               cfg_cir,
  input  logic [31:0]               cfg_cbs,
  input  logic [TIME_WIDTH-1:0]     cfg_max_residence_time,
  output logic                      tb_start_flag,
  output logic                      tb_match_finish_flag,
  output logic                      tb_read_end_flag,
  output logic [15:0]               tb_frame_length,
  output logic [31:0]               tb_cir,
  output logic [31:0]               tb_cbs,
  output logic [TIME_WIDTH-1:0]     tb_arrival_time,
  output logic [TIME_WIDTH-1:0]     tb_group_eligibility_time,
  output logic [TIME_WIDTH-1:0]     tb_bucket_empty_time,
  output logic [TIME_WIDTH-1:0]     tb_max_residence_time,
  input  logic                      tb_start_match_flag,
  input  logic                      tb_frame_discard_flag,
  input  logic                      tb_frame_eligible_time_OK,
  input  logic [TIME_WIDTH-1:0]     tb_frame_eligible_time,
  input  logic [TIME_WIDTH-1:0]     tb_update_bucket_empty_time,
  input  logic [TIME_WIDTH-1:0]     tb_update_group_eligibility_time,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [FLOW_ID_WIDTH-1:0]  res_flow_id,
  output logic                      res_discard,
  output logic                      res_timeout,
  output logic [TIME_WIDTH-1:0]     res_eligible_time
);

  localparam int unsigned CNT_W = $clog2(TB_TIMEOUT + 1);

  ats_state_e                state;
  logic [FLOW_ID_WIDTH-1:0]  flow_q;
  logic [15:0]               len_q;
  logic [TIME_WIDTH-1:0]     arr_q;
  logic [GROUP_ID_WIDTH-1:0] group_q;
  logic                      started_q;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      timeout_hit;

  flow_cfg_t                 cfg_data;
  flow_cfg_t                 rd_cfg;
  logic [TIME_WIDTH-1:0]     rd_bet;
  logic [TIME_WIDTH-1:0]     rd_get;
  logic [FLOW_ID_WIDTH-1:0]  rd_flow_id;
  logic                      st_wr_en;

  assign cfg_data   = '{valid: 1'b1, group: cfg_group_id, cir: cfg_cir,
                        cbs: cfg_cbs, max_res: cfg_max_residence_time};
  assign rd_flow_id = (state == ST_IDLE) ? desc_flow_id : flow_q;
  assign st_wr_en   = (state == ST_WRITEBACK) && !tb_frame_discard_flag;
  assign cnt_inc    = cnt + CNT_W'(1);

  // A token-bucket event arriving in the expiry cycle takes precedence.
  always_comb begin
    timeout_hit = 1'b0;
    if (cnt_inc >= CNT_W'(TB_TIMEOUT)) begin
      case (state)
        ST_MATCH:   timeout_hit = !tb_start_match_flag;
        ST_FINISH:  timeout_hit = 1'b1;
        ST_WAIT_OK: timeout_hit = !tb_frame_eligible_time_OK;
        default:    timeout_hit = 1'b0;
      endcase
    end
  end

  ats_flow_table #(
    .FLOW_NUM      (FLOW_NUM),
    .FLOW_ID_WIDTH (FLOW_ID_WIDTH)
  ) u_table (
    .clk                       (clk),
    .reset                     (reset),
    .cfg_wr_en                 (cfg_wr_en),
    .cfg_flow_id               (cfg_flow_id),
    .cfg_data                  (cfg_data),
    .st_wr_en                  (st_wr_en),
    .st_flow_id                (flow_q),
    .st_group_id               (group_q),
    .st_bucket_empty_time      (tb_update_bucket_empty_time),
    .st_group_eligibility_time (tb_update_group_eligibility_time),
    .rd_flow_id                (rd_flow_id),
    .rd_cfg                    (rd_cfg),
    .rd_bucket_empty_time      (rd_bet),
    .rd_group_eligibility_time (rd_get)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                     <= ST_IDLE;
      flow_q                    <= '0;
      len_q                     <= '0;
      arr_q                     <= '0;
      group_q                   <= '0;
      started_q                 <= 1'b0;
      cnt                       <= '0;
      desc_ready                <= 1'b1;
      tb_start_flag             <= 1'b0;
      tb_match_finish_flag      <= 1'b0;
      tb_read_end_flag          <= 1'b0;
      tb_frame_length           <= '0;
      tb_cir                    <= '0;
      tb_cbs                    <= '0;
      tb_arrival_time           <= '0;
      tb_group_eligibility_time <= '0;
      tb_bucket_empty_time      <= '0;
      tb_max_residence_time     <= '0;
      res_valid                 <= 1'b0;
      res_flow_id               <= '0;
      res_discard               <= 1'b0;
      res_timeout               <= 1'b0;
      res_eligible_time         <= '0;
    end else begin
      tb_start_flag        <= 1'b0;
      tb_match_finish_flag <= 1'b0;
      tb_read_end_flag     <= 1'b0;
      if (timeout_hit) begin
        res_valid         <= 1'b1;
        res_flow_id       <= flow_q;
        res_discard       <= 1'b1;
        res_timeout       <= 1'b1;
        res_eligible_time <= arr_q;
        state             <= ST_RESULT;
      end else begin
        case (state)
          ST_IDLE: begin
            if (desc_valid && desc_ready) begin
              flow_q     <= desc_flow_id;
              len_q      <= desc_frame_length;
              arr_q      <= desc_arrival_time;
              desc_ready <= 1'b0;
              state      <= ST_LOOKUP;
            end
          end
          // Snapshot table contents; they stay frozen for the whole frame.
          ST_LOOKUP: begin
            tb_frame_length           <= len_q;
            tb_cir                    <= rd_cfg.cir;
            tb_cbs                    <= rd_cfg.cbs;
            tb_arrival_time           <= arr_q;
            tb_group_eligibility_time <= rd_get;
            tb_bucket_empty_time      <= rd_bet;
            tb_max_residence_time     <= rd_cfg.max_res;
            group_q                   <= rd_cfg.group;
            cnt                       <= '0;
            if (!rd_cfg.valid) begin
              started_q         <= 1'b0;
              res_valid         <= 1'b1;
              res_flow_id       <= flow_q;
              res_discard       <= 1'b1;
              res_timeout       <= 1'b0;
              res_eligible_time <= arr_q;
              state             <= ST_RESULT;
            end else begin
              started_q     <= 1'b1;
              tb_start_flag <= 1'b1;
              state         <= ST_START;
            end
          end
          ST_START: begin
            cnt   <= cnt_inc;
            state <= ST_MATCH;
          end
          ST_MATCH: begin
            cnt <= cnt_inc;
            if (tb_start_match_flag) begin
              tb_match_finish_flag <= 1'b1;
              state                <= ST_FINISH;
            end
          end
          ST_FINISH: begin
            cnt   <= cnt_inc;
            state <= ST_WAIT_OK;
          end
          ST_WAIT_OK: begin
            cnt <= cnt_inc;
            if (tb_frame_eligible_time_OK) state <= ST_WRITEBACK;
          end
          ST_WRITEBACK: begin
            res_valid         <= 1'b1;
            res_flow_id       <= flow_q;
            res_discard       <= tb_frame_discard_flag;
            res_timeout       <= 1'b0;
            res_eligible_time <= tb_frame_eligible_time;
            state             <= ST_RESULT;
          end
          ST_RESULT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (started_q) begin
                tb_read_end_flag <= 1'b1;
                state            <= ST_RELEASE;
              end else begin
                desc_ready <= 1'b1;
                state      <= ST_IDLE;
              end
            end
          end
          ST_RELEASE: begin
            desc_ready <= 1'b1;
            state      <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
